// File: rtl/packet_rr_arbiter_pkg.sv
// Shared router arbitration types and helpers.
// Used by the switch/VC arbiters and the VC allocator.
package packet_rr_arbiter_pkg;

    typedef enum logic {
        ARB_UNLOCKED = 1'b0,
        ARB_LOCKED   = 1'b1
    } arb_state_t;

    // A single requester still needs a 1-bit index.
    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned rr_next(
        input int unsigned idx,
        input int unsigned n
    );
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/packet_rr_arbiter_if.sv
// Request/grant bundle between requesters and the arbiter.
// master = requester side, slave = arbiter side.
interface packet_rr_arbiter_if
    import packet_rr_arbiter_pkg::*;
#(
    parameter int NUM_REQS = 4,
    parameter int IDX_BITS = idx_bits(NUM_REQS)
);
    logic [NUM_REQS-1:0] req_valid;
    logic [NUM_REQS-1:0] req_tail;
    logic                out_ready;
    logic [NUM_REQS-1:0] grant;
    logic                grant_valid;
    logic [IDX_BITS-1:0] grant_index;
    logic                locked;
    logic [IDX_BITS-1:0] owner;

    modport master (
        output req_valid, req_tail, out_ready,
        input  grant, grant_valid, grant_index, locked, owner
    );

    modport slave (
        input  req_valid, req_tail, out_ready,
        output grant, grant_valid, grant_index, locked, owner
    );
endinterface

// File: rtl/packet_rr_arbiter_priority_encoder.sv
// Lowest-set-bit priority encoder; yields 0 for an all-zero input.
// Feeds grant_index from the one-hot grant.
module priority_encoder
    import packet_rr_arbiter_pkg::*;
#(
    parameter int NUM_INPUTS = 4,
    parameter int IDX_BITS   = idx_bits(NUM_INPUTS)
) (
    input  logic [NUM_INPUTS-1:0] req,
    output logic [IDX_BITS-1:0]   idx
);
    always_comb begin
        idx = '0;
        for (int i = NUM_INPUTS - 1; i >= 0; i--) begin
            if (req[i]) idx = IDX_BITS'(i);
        end
    end
endmodule

// File: rtl/packet_rr_arbiter.sv
// Round-robin arbiter that locks onto a requester from head to tail flit.
// Drives the crossbar select and output-VC muxes via grant_index.
module packet_rr_arbiter
    import packet_rr_arbiter_pkg::*;
#(
    parameter int NUM_REQS = 4,
    parameter int IDX_BITS = idx_bits(NUM_REQS)
) (
    input logic                clk,
    input logic                reset,
    packet_rr_arbiter_if.slave bus
);
    arb_state_t          state;
    logic [IDX_BITS-1:0] ptr;
    logic [IDX_BITS-1:0] owner_q;
    logic [NUM_REQS-1:0] rot;
    logic [NUM_REQS-1:0] rr_grant;
    logic [NUM_REQS-1:0] grant_c;
    logic [IDX_BITS-1:0] win_idx;
    logic                found;
    logic                xfer;
    logic                tail;

    function automatic logic [IDX_BITS-1:0] wrap(input int v);
        return IDX_BITS'((v >= NUM_REQS) ? v - NUM_REQS : v);
    endfunction

    // Rotate right by ptr, pick first set bit, rotate the pick back.
    always_comb begin
        rot      = '0;
        rr_grant = '0;
        found    = 1'b0;
        for (int i = 0; i < NUM_REQS; i++) begin
            rot[i] = bus.req_valid[wrap(i + int'(ptr))];
        end
        for (int i = 0; i < NUM_REQS; i++) begin
            if (rot[i] && !found) begin
                found = 1'b1;
                rr_grant[wrap(i + int'(ptr))] = 1'b1;
            end
        end
    end

    always_comb begin
        grant_c = '0;
        if (reset) begin
            grant_c = '0;
        end else if (state == ARB_LOCKED) begin
            grant_c[owner_q] = bus.req_valid[owner_q];
        end else begin
            grant_c = rr_grant;
        end
    end

    priority_encoder #(
        .NUM_INPUTS (NUM_REQS),
        .IDX_BITS   (IDX_BITS)
    ) u_penc (
        .req (grant_c),
        .idx (win_idx)
    );

    assign xfer = (|grant_c) && bus.out_ready;
    assign tail = |(grant_c & bus.req_tail);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ARB_UNLOCKED;
            ptr     <= '0;
            owner_q <= '0;
        end else if (xfer) begin
            unique case (state)
                ARB_UNLOCKED: begin
                    if (tail) begin
                        ptr <= IDX_BITS'(rr_next(32'(win_idx),
                                                 32'(NUM_REQS)));
                    end else begin
                        state   <= ARB_LOCKED;
                        owner_q <= win_idx;
                    end
                end
                ARB_LOCKED: begin
                    if (tail) begin
                        state <= ARB_UNLOCKED;
                        ptr   <= IDX_BITS'(rr_next(32'(owner_q),
                                                   32'(NUM_REQS)));
                    end
                end
                default: state <= ARB_UNLOCKED;
            endcase
        end
    end

    assign bus.grant       = grant_c;
    assign bus.grant_valid = |grant_c;
    assign bus.grant_index = win_idx;
    assign bus.locked      = (state == ARB_LOCKED);
    assign bus.owner       = owner_q;
endmodule
